// File: rtl/result_drain.sv
// Drains the finished result matrix from the output BRAM read port and
// presents it as a valid/ready stream with a last-word marker.
module result_drain #(
    parameter int WIDTH             = 16,
    parameter int CHUNK_SIZE        = 4,
    parameter int W_OUTER_DIMENSION = 64,
    parameter int I_OUTER_DIMENSION = 2754,
    parameter int ADDR_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          out_en,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   out_dout,
    output logic [WIDTH*CHUNK_SIZE-1:0]   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast
);

    localparam int DW        = WIDTH * CHUNK_SIZE;
    localparam int NUM_WORDS = (W_OUTER_DIMENSION / CHUNK_SIZE) * I_OUTER_DIMENSION;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_WIDTH:0] rd_cnt;
    logic                inflight;
    logic                inflight_last;
    logic [1:0]          count;
    logic [DW-1:0]       data0;
    logic [DW-1:0]       data1;
    logic                last0;
    logic                last1;
    logic                busy_r;
    logic                done_r;

    logic                pop;
    logic                is_last_rd;
    logic                credit;
    logic                issue;

    assign pop        = (count != 2'd0) & m_tready;
    assign is_last_rd = (rd_cnt == LAST_CNT);
    // Occupancy plus outstanding read, less the word leaving this cycle, must stay below two.
    assign credit     = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue      = (state == READ) & credit;

    assign out_en   = issue;
    assign out_addr = rd_cnt[ADDR_WIDTH-1:0];
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = data0;
    assign m_tlast  = last0;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state decode of the drain sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ: begin
                if (issue && is_last_rd) begin
                    state_next = FLUSH;
                end else begin
                    state_next = READ;
                end
            end
            FLUSH: begin
                // Leave as the final beat is accepted so done follows it by one cycle.
                if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_next = FIN;
                end else begin
                    state_next = FLUSH;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_next;
            busy_r <= (state_next != IDLE);
            done_r <= (state_next == FIN);
        end
    end

    // Read address counter and in-flight tracking for the one-cycle BRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                rd_cnt <= '0;
            end else if (issue && !is_last_rd) begin
                rd_cnt <= rd_cnt + (ADDR_WIDTH + 1)'(1);
            end else begin
                rd_cnt <= rd_cnt;
            end
            inflight      <= issue;
            inflight_last <= issue & is_last_rd;
        end
    end

    // Two-entry shifting FIFO; entry 0 is always the stream head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= out_dout;
                        last1 <= inflight_last;
                    end else begin
                        data0 <= out_dout;
                        last0 <= inflight_last;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= out_dout;
                        last0 <= inflight_last;
                    end else begin
                        data1 <= out_dout;
                        last1 <= inflight_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    count <= count - 2'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: a reduced-size instance for directed
// timing/back-pressure/reset scenarios and a default-size instance for a full drain.
module tb_result_drain;

    localparam int L_WORDS = 44064;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_start, s_busy, s_done, s_out_en, s_tvalid, s_tready, s_tlast;
    logic [15:0] s_out_addr;
    logic [63:0] s_out_dout, s_tdata;
    logic        l_start, l_busy, l_done, l_out_en, l_tvalid, l_tready, l_tlast;
    logic [15:0] l_out_addr;
    logic [63:0] l_out_dout, l_tdata;

    result_drain #(.WIDTH(16), .CHUNK_SIZE(4), .W_OUTER_DIMENSION(8),
                   .I_OUTER_DIMENSION(3), .ADDR_WIDTH(16)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .out_en(s_out_en), .out_addr(s_out_addr), .out_dout(s_out_dout),
        .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_tready), .m_tlast(s_tlast)
    );

    result_drain dut_l (
        .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
        .out_en(l_out_en), .out_addr(l_out_addr), .out_dout(l_out_dout),
        .m_tdata(l_tdata), .m_tvalid(l_tvalid), .m_tready(l_tready), .m_tlast(l_tlast)
    );

    // BRAM models: word i holds i + 0x100, one-cycle read latency.
    always @(posedge clk) begin
        if (s_out_en) s_out_dout <= 64'h100 + 64'(s_out_addr);
        if (l_out_en) l_out_dout <= 64'h100 + 64'(l_out_addr);
    end

    int checks = 0;
    int errors = 0;
    logic [64:0] s_q[$];
    logic [64:0] l_q[$];
    int          s_issued = 0, s_beats = 0, s_dones = 0;
    logic [15:0] s_exp_addr = 16'd0;
    int          l_dones = 0;
    logic [15:0] l_max_addr = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Small-instance monitor: address order, outstanding bound, scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            s_issued   = 0;
            s_beats    = 0;
            s_exp_addr = 16'd0;
        end else begin
            if (s_out_en) begin
                check("s_addr", 64'(s_out_addr), 64'(s_exp_addr));
                s_exp_addr = s_exp_addr + 16'd1;
                s_issued++;
            end
            if (s_tvalid && s_tready) begin
                if (s_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s_extra_beat: got beat %0h expected none", s_tdata);
                end else begin
                    logic [64:0] e;
                    e = s_q.pop_front();
                    check("s_data", s_tdata, e[63:0]);
                    check("s_last", 64'(s_tlast), 64'(e[64]));
                end
                s_beats++;
            end
            if (s_out_en) check("s_outstanding_le2", 64'(s_issued - s_beats <= 2), 64'd1);
            if (s_done) s_dones++;
            if (s_start && !s_busy) s_exp_addr = 16'd0;
        end
    end

    // Large-instance monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (l_out_en && l_out_addr > l_max_addr) l_max_addr = l_out_addr;
            if (l_tvalid && l_tready) begin
                if (l_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL l_extra_beat: got beat %0h expected none", l_tdata);
                end else begin
                    logic [64:0] e;
                    e = l_q.pop_front();
                    check("l_data", l_tdata, e[63:0]);
                    check("l_last", 64'(l_tlast), 64'(e[64]));
                end
            end
            if (l_done) l_dones++;
        end
    end

    // mode 1 nominal, 2 stall 3..7, 3 ready toggling, 4 extra starts, 5 reset at 5
    task automatic run_small(input int mode, input int ncyc);
        int n_exp;
        int dones0;
        n_exp  = (mode == 5) ? 2 : 6;
        dones0 = s_dones;
        for (int i = 0; i < n_exp; i++) s_q.push_back({(i == 5), 64'h100 + 64'(i)});
        for (int rel = 0; rel < ncyc; rel++) begin
            @(posedge clk);
            #1;
            s_start = (rel == 0) || (mode == 4 && (rel == 4 || rel == 9));
            if (mode == 2)      s_tready = !(rel >= 3 && rel <= 7);
            else if (mode == 3) s_tready = (rel % 2 == 0);
            else                s_tready = 1'b1;
            if (mode == 5) rst = (rel == 5);
            @(negedge clk);
            if (mode == 1 || mode == 4) begin
                check("busy", 64'(s_busy), 64'(rel >= 1 && rel <= 9));
                check("done", 64'(s_done), 64'(rel == 9));
                check("out_en", 64'(s_out_en), 64'(rel >= 1 && rel <= 6));
                check("tvalid", 64'(s_tvalid), 64'(rel >= 3 && rel <= 8));
            end
            if (mode == 2 && rel >= 3 && rel <= 7) begin
                check("stall_valid", 64'(s_tvalid), 64'd1);
                check("stall_data", s_tdata, 64'h100);
                check("stall_out_en", 64'(s_out_en), 64'd0);
            end
            if (mode == 5 && rel == 5) begin
                check("rst_busy", 64'(s_busy), 64'd0);
                check("rst_done", 64'(s_done), 64'd0);
                check("rst_out_en", 64'(s_out_en), 64'd0);
                check("rst_addr", 64'(s_out_addr), 64'd0);
                check("rst_valid", 64'(s_tvalid), 64'd0);
                check("rst_last", 64'(s_tlast), 64'd0);
                check("rst_data", s_tdata, 64'd0);
            end
            if (mode == 5 && rel > 5) begin
                check("abort_busy", 64'(s_busy), 64'd0);
                check("abort_done", 64'(s_done), 64'd0);
            end
        end
        s_start  = 1'b0;
        rst      = 1'b0;
        s_tready = 1'b1;
        check("done_count", 64'(s_dones - dones0), (mode == 5) ? 64'd0 : 64'd1);
        check("scoreboard_drained", 64'(s_q.size()), 64'd0);
        s_q.delete();
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        s_start  = 1'b0;
        l_start  = 1'b0;
        s_tready = 1'b1;
        l_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(s_busy), 64'd0);
        check("reset_out_en", 64'(s_out_en), 64'd0);
        check("reset_valid", 64'(s_tvalid), 64'd0);
        check("reset_data", s_tdata, 64'd0);
        check("reset_addr", 64'(s_out_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_small(1, 13);
        run_small(2, 24);
        run_small(3, 24);
        run_small(4, 13);
        run_small(5, 10);
        run_small(1, 13);

        for (int i = 0; i < L_WORDS; i++) l_q.push_back({(i == L_WORDS - 1), 64'h100 + 64'(i)});
        @(posedge clk);
        #1 l_start = 1'b1;
        @(posedge clk);
        #1 l_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50000 && !seen; k++) begin
            @(negedge clk);
            if (l_dones > 0) seen = 1'b1;
        end
        check("l_done_seen", 64'(seen), 64'd1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("l_done_count", 64'(l_dones), 64'd1);
        check("l_max_addr", 64'(l_max_addr), 64'(L_WORDS - 1));
        check("l_drained", 64'(l_q.size()), 64'd0);
        check("l_busy_end", 64'(l_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
